// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - time-multiplexed multi-voice sine tone synthesizer with saturated signed mix
// One shared registered quarter-wave ROM serves every voice; one voice is addressed per RUN cycle.
module tone_synth #(
  parameter int VOICES = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                                           clk_in,
  input  logic                                           rst_n_in,
  input  logic                                           sample_tick_in,
  input  logic                                           cfg_we_in,
  input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] cfg_voice_in,
  input  logic [4:0]                                     cfg_freq_id_in,
  input  logic [3:0]                                     cfg_amp_in,
  output logic [OUT_W-1:0]                               sample_out,
  output logic                                           sample_valid_out,
  output logic                                           busy_out,
  output logic                                           overflow_out,
  output logic                                           missed_tick_out
);

  localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int LOGV    = $clog2(VOICES);
  localparam int ACC_MIN = OUT_W + SHIFT + LOGV + 4;
  localparam int ACC_FS  = LOGV + 15;
  localparam int ACC_W   = (ACC_MIN > ACC_FS) ? ACC_MIN : ACC_FS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Quarter-wave table round(768*sin(pi*c/512)), c = 0..256, from a Q30 Taylor series.
  function automatic logic [257*10-1:0] build_sine();
    logic [257*10-1:0] t;
    longint x, term, sum;
    t = '0;
    for (int c = 0; c <= 256; c++) begin
      x    = (64'sd3373259426 * c) / 512;
      term = x;
      sum  = x;
      for (int n = 1; n <= 9; n++) begin
        term = -((((term * x) >>> 30) * x) >>> 30) / ((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      t[c*10 +: 10] = 10'((sum * 768 + (64'sd1 <<< 29)) >>> 30);
    end
    return t;
  endfunction

  localparam logic [257*10-1:0] SINE_TABLE = build_sine();

  function automatic logic [15:0] freq_inc(input logic [4:0] id);
    logic [15:0] inc;
    case (id)
      5'd0:  inc = 16'd1817;  5'd1:  inc = 16'd1925;  5'd2:  inc = 16'd2040;  5'd3:  inc = 16'd2161;
      5'd4:  inc = 16'd2289;  5'd5:  inc = 16'd2426;  5'd6:  inc = 16'd2570;  5'd7:  inc = 16'd2723;
      5'd8:  inc = 16'd2884;  5'd9:  inc = 16'd3056;  5'd10: inc = 16'd3238;  5'd11: inc = 16'd3430;
      5'd12: inc = 16'd3634;  5'd13: inc = 16'd3850;  5'd14: inc = 16'd4079;  5'd15: inc = 16'd4322;
      5'd16: inc = 16'd4579;  5'd17: inc = 16'd4851;  5'd18: inc = 16'd5140;  5'd19: inc = 16'd5445;
      5'd20: inc = 16'd5769;  5'd21: inc = 16'd6112;  5'd22: inc = 16'd6475;  5'd23: inc = 16'd6860;
      5'd24: inc = 16'd7268;  5'd25: inc = 16'd7700;  5'd26: inc = 16'd8158;  5'd27: inc = 16'd8643;
      5'd28: inc = 16'd9157;  5'd29: inc = 16'd9702;  5'd30: inc = 16'd10279;
      default: inc = 16'd0;
    endcase
    return inc;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, TAIL, OUT} state_t;

  state_t                  state, state_next;
  logic [VW-1:0]           voice;
  logic [15:0]             phase   [VOICES];
  logic [4:0]              freq_id [VOICES];
  logic [3:0]              amp     [VOICES];
  logic [9:0]              rom_q;
  logic                    neg_q;
  logic [3:0]              amp_q;
  logic signed [ACC_W-1:0] acc;

  logic [9:0]              idx;
  logic [8:0]              fold;
  logic [13:0]             mag;
  logic signed [ACC_W-1:0] term, acc_sum, shifted;
  logic                    sat_hi, sat_lo;

  always_comb begin
    idx     = phase[voice][15:6];
    fold    = idx[8] ? (9'd256 - {1'b0, idx[7:0]}) : {1'b0, idx[7:0]};
    mag     = {4'b0, rom_q} * {10'b0, amp_q};
    term    = $signed({{(ACC_W-14){1'b0}}, mag});
    if (neg_q) term = -term;
    acc_sum = acc + term;
    shifted = acc_sum >>> SHIFT;
    sat_hi  = shifted > SAT_MAX;
    sat_lo  = shifted < SAT_MIN;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick_in) state_next = RUN;
      RUN:     if (voice == VW'(VOICES - 1)) state_next = TAIL;
      TAIL:    state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first RUN cycle only issues an address, so busy starts one cycle after the tick edge.
  assign busy_out = (state == TAIL) || (state == OUT) || ((state == RUN) && (voice != '0));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      voice            <= '0;
      rom_q            <= '0;
      neg_q            <= 1'b0;
      amp_q            <= '0;
      acc              <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      overflow_out     <= 1'b0;
      missed_tick_out  <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        phase[v]   <= '0;
        freq_id[v] <= 5'd31;
        amp[v]     <= '0;
      end
    end else begin
      state            <= state_next;
      sample_valid_out <= (state == TAIL);
      if (sample_tick_in && (state != IDLE)) missed_tick_out <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick_in) begin
            voice <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          rom_q <= SINE_TABLE[int'(fold)*10 +: 10];
          neg_q <= idx[9];
          amp_q <= (freq_id[voice] == 5'd31) ? 4'd0 : amp[voice];
          if (voice != '0) acc <= acc_sum;
          voice <= voice + 1'b1;
        end
        TAIL: begin
          acc          <= acc_sum;
          overflow_out <= sat_hi || sat_lo;
          if (sat_hi)      sample_out <= SAT_MAX[OUT_W-1:0];
          else if (sat_lo) sample_out <= SAT_MIN[OUT_W-1:0];
          else             sample_out <= shifted[OUT_W-1:0];
        end
        default: ;
      endcase

      // A config write beats the phase advance of the voice being addressed this cycle.
      for (int v = 0; v < VOICES; v++) begin
        if (cfg_we_in && (int'(cfg_voice_in) == v)) begin
          freq_id[v] <= cfg_freq_id_in;
          amp[v]     <= cfg_amp_in;
          phase[v]   <= '0;
        end else if ((state == RUN) && (int'(voice) == v)) begin
          phase[v] <= phase[v] + freq_inc(freq_id[v]);
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - directed self-checking bench for tone_synth
module tb_tone_synth;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        sample_tick_in;
  logic        cfg_we_in;
  logic [1:0]  cfg_voice_in;
  logic [4:0]  cfg_freq_id_in;
  logic [3:0]  cfg_amp_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic        busy_out;
  logic        overflow_out;
  logic        missed_tick_out;

  int checks   = 0;
  int failures = 0;

  tone_synth #(.VOICES(4), .OUT_W(16), .SHIFT(0)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .sample_tick_in   (sample_tick_in),
    .cfg_we_in        (cfg_we_in),
    .cfg_voice_in     (cfg_voice_in),
    .cfg_freq_id_in   (cfg_freq_id_in),
    .cfg_amp_in       (cfg_amp_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .busy_out         (busy_out),
    .overflow_out     (overflow_out),
    .missed_tick_out  (missed_tick_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int v, input int id, input int a);
    cfg_we_in      = 1'b1;
    cfg_voice_in   = 2'(v);
    cfg_freq_id_in = 5'(id);
    cfg_amp_in     = 4'(a);
    @(negedge clk_in);
    cfg_we_in      = 1'b0;
  endtask

  // lat counts clock edges since the edge that accepted the tick.
  task automatic wait_valid(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!sample_valid_out && lat < 20) begin
      if (busy_out) busy_cnt++;
      @(negedge clk_in);
      lat++;
    end
    if (busy_out) busy_cnt++;
  endtask

  task automatic frame(input string tag, input int exp_s, input int exp_ovf, output int bc);
    int lat;
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    wait_valid(0, lat, bc);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_sample"}, int'($signed(sample_out)), exp_s);
    check({tag, "_overflow"}, int'(overflow_out), exp_ovf);
    @(negedge clk_in);
    check({tag, "_valid_pulse_end"}, int'(sample_valid_out), 0);
  endtask

  initial begin
    int bc, lat, seen;
    rst_n_in       = 1'b0;
    sample_tick_in = 1'b0;
    cfg_we_in      = 1'b0;
    cfg_voice_in   = '0;
    cfg_freq_id_in = '0;
    cfg_amp_in     = '0;
    repeat (3) @(negedge clk_in);
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_overflow", int'(overflow_out), 0);
    check("rst_missed", int'(missed_tick_out), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    frame("idle", 0, 0, bc);
    check("idle_busy_cycles", bc, 5);

    cfg_write(0, 30, 1);
    frame("sv_t1", 0, 0, bc);
    frame("sv_t2", 639, 0, bc);
    frame("sv_t3", 708, 0, bc);
    frame("sv_t4", 145, 0, bc);
    frame("sv_t5", -550, 0, bc);

    for (int v = 0; v < 4; v++) cfg_write(v, 30, 15);
    frame("sat_t1", 0, 0, bc);
    frame("sat_t2", 32767, 1, bc);
    frame("sat_t3", 32767, 1, bc);
    frame("sat_t4", 8700, 0, bc);
    frame("sat_t5", -32768, 1, bc);

    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    cfg_write(0, 30, 1);
    cfg_write(1, 31, 15);
    frame("mute_t1", 0, 0, bc);
    check("missed_before", int'(missed_tick_out), 0);

    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    wait_valid(2, lat, bc);
    check("mute_t2_latency", lat, 5);
    check("mute_t2_sample", int'($signed(sample_out)), 639);
    check("missed_after", int'(missed_tick_out), 1);
    @(negedge clk_in);

    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    wait_valid(0, lat, bc);
    check("thru_t3_sample", int'($signed(sample_out)), 708);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    wait_valid(0, lat, bc);
    check("thru_t4_latency", lat, 5);
    check("thru_t4_sample", int'($signed(sample_out)), 145);
    check("missed_sticky", int'(missed_tick_out), 1);
    @(negedge clk_in);

    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("midrst_sample", int'(sample_out), 0);
    check("midrst_valid", int'(sample_valid_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    check("midrst_overflow", int'(overflow_out), 0);
    check("midrst_missed", int'(missed_tick_out), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (sample_valid_out) seen++;
    end
    check("midrst_no_valid", seen, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    frame("post_rst", 0, 0, bc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
